// File: rtl/div_seq_ctrl.sv
// Sequencer between the execute stage and a shared unsigned iterative divider.
// Converts signed operands to magnitudes, drives the core, then applies sign fix-up into HI/LO.
module div_seq_ctrl #(
  parameter int W       = 32,
  parameter int TIMEOUT = 64
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_req_valid,
  input  logic         i_req_signed,
  input  logic [W-1:0] i_req_a,
  input  logic [W-1:0] i_req_b,
  output logic         o_stall,
  output logic         o_done,
  output logic         o_err,
  output logic         o_hilo_we,
  output logic [W-1:0] o_lo_out,
  output logic [W-1:0] o_hi_out,
  output logic [W-1:0] o_div_a,
  output logic [W-1:0] o_div_b,
  output logic         o_div_start,
  input  logic [W-1:0] i_div_q,
  input  logic [W-1:0] i_div_r,
  input  logic         i_div_busy
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] C_ARM_MAX  = CW'(2);
  localparam logic [CW-1:0] C_TMO_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_ARM   = 3'd2,
    S_RUN   = 3'd3,
    S_FIX   = 3'd4,
    S_WRITE = 3'd5,
    S_ZERO  = 3'd6,
    S_FAIL  = 3'd7
  } state_t;

  state_t r_state;
  state_t w_next;

  logic          r_sign_q;
  logic          r_sign_r;
  logic [W-1:0]  r_raw_a;
  logic [W-1:0]  r_div_a;
  logic [W-1:0]  r_div_b;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_lo;
  logic [W-1:0]  r_hi;
  logic          r_div_start;
  logic          r_done;
  logic          r_err;
  logic          w_accept;

  // Two's-complement negate, mod 2^W
  function automatic logic [W-1:0] f_neg(input logic [W-1:0] x);
    return ~x + {{(W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [W-1:0] f_mag(input logic s, input logic [W-1:0] x);
    return (s && x[W-1]) ? f_neg(x) : x;
  endfunction

  assign w_accept = (r_state == S_IDLE) && i_req_valid;

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_req_valid) begin
          w_next = (i_req_b == {W{1'b0}}) ? S_ZERO : S_START;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_START: w_next = S_ARM;
      S_ARM: begin
        // A core that never raises busy is assumed to have finished already
        if (i_div_busy) begin
          w_next = S_RUN;
        end else if (r_cnt >= C_ARM_MAX) begin
          w_next = S_FIX;
        end else begin
          w_next = S_ARM;
        end
      end
      S_RUN: begin
        if (!i_div_busy) begin
          w_next = S_FIX;
        end else if (r_cnt == C_TMO_LAST) begin
          w_next = S_FAIL;
        end else begin
          w_next = S_RUN;
        end
      end
      S_FIX:   w_next = S_WRITE;
      S_WRITE: w_next = S_IDLE;
      S_ZERO:  w_next = S_WRITE;
      S_FAIL:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request capture: signs, raw dividend and operand magnitudes
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_raw_a  <= {W{1'b0}};
      r_div_a  <= {W{1'b0}};
      r_div_b  <= {W{1'b0}};
    end else if (w_accept) begin
      r_sign_q <= i_req_signed & (i_req_a[W-1] ^ i_req_b[W-1]);
      r_sign_r <= i_req_signed & i_req_a[W-1];
      r_raw_a  <= i_req_a;
      r_div_a  <= f_mag(i_req_signed, i_req_a);
      r_div_b  <= f_mag(i_req_signed, i_req_b);
    end
  end

  // Cycle counter: 0 in START, reaches TIMEOUT in the FAIL cycle
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= {CW{1'b0}};
    end else if (w_accept) begin
      r_cnt <= {CW{1'b0}};
    end else if ((r_state == S_START) || (r_state == S_ARM) || (r_state == S_RUN)) begin
      r_cnt <= r_cnt + C_CNT_ONE;
    end
  end

  // HI/LO result registers; hold between operations and across a timeout
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lo <= {W{1'b0}};
      r_hi <= {W{1'b0}};
    end else if (r_state == S_FIX) begin
      r_lo <= r_sign_q ? f_neg(i_div_q) : i_div_q;
      r_hi <= r_sign_r ? f_neg(i_div_r) : i_div_r;
    end else if (r_state == S_ZERO) begin
      r_lo <= {W{1'b1}};
      r_hi <= r_raw_a;
    end
  end

  // Registered pulses, each high for the single cycle of its target state
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_div_start <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_div_start <= (w_next == S_START);
      r_done      <= (w_next == S_WRITE);
      r_err       <= (w_next == S_FAIL);
    end
  end

  assign o_stall     = i_req_valid | (r_state != S_IDLE) | r_done | r_err;
  assign o_done      = r_done;
  assign o_hilo_we   = r_done;
  assign o_err       = r_err;
  assign o_lo_out    = r_lo;
  assign o_hi_out    = r_hi;
  assign o_div_a     = r_div_a;
  assign o_div_b     = r_div_b;
  assign o_div_start = r_div_start;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl with a behavioural iterative-divider stub.
// Expected HI/LO values are queued at issue and popped when done is observed.
module tb_div_seq_ctrl;

  localparam int W = 32;
  localparam int TIMEOUT = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_signed;
  logic [W-1:0] req_a, req_b;
  logic         stall, done, err, hilo_we, div_start, div_busy;
  logic [W-1:0] lo_out, hi_out, div_a, div_b, div_q, div_r;

  int core_n = 4;
  bit stub   = 1'b0;
  int m_cnt;

  int pass_cnt  = 0;
  int check_cnt = 0;
  logic [63:0] sb_q[$];

  div_seq_ctrl #(.W(W), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_signed(req_signed),
    .i_req_a(req_a), .i_req_b(req_b), .o_stall(stall), .o_done(done), .o_err(err),
    .o_hilo_we(hilo_we), .o_lo_out(lo_out), .o_hi_out(hi_out), .o_div_a(div_a),
    .o_div_b(div_b), .o_div_start(div_start), .i_div_q(div_q), .i_div_r(div_r),
    .i_div_busy(div_busy)
  );

  always #5 clk = ~clk;

  // Unsigned core stub: busy for core_n cycles after start (0 = never busy; stub = stuck busy)
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      div_busy <= 1'b0; m_cnt <= 0; div_q <= '0; div_r <= '0;
    end else if (div_start) begin
      div_q    <= (div_b != 0) ? div_a / div_b : '1;
      div_r    <= (div_b != 0) ? div_a % div_b : div_a;
      div_busy <= (core_n != 0) || stub;
      m_cnt    <= core_n;
    end else if (div_busy && !stub) begin
      if (m_cnt <= 1) div_busy <= 1'b0;
      m_cnt <= m_cnt - 1;
    end
  end

  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] lo, hi;
    if (b == 32'd0) begin
      lo = 32'hFFFF_FFFF; hi = a;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      lo = 32'h8000_0000; hi = 32'd0;
    end else if (s) begin
      lo = 32'($signed(a) / $signed(b)); hi = 32'($signed(a) % $signed(b));
    end else begin
      lo = a / b; hi = a % b;
    end
    return {lo, hi};
  endfunction

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_signed = 1'b0; req_a = '0; req_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check_cnt++;
    if ({stall, done, err, hilo_we, div_start} !== 5'b0)
      $display("FAIL reset_ctl: got %b want 00000", {stall, done, err, hilo_we, div_start});
    else pass_cnt++;
    check_cnt++;
    if ({lo_out, hi_out, div_a, div_b} !== 128'd0)
      $display("FAIL reset_data: got %h want 0", {lo_out, hi_out, div_a, div_b});
    else pass_cnt++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Issues one op in the current (IDLE) cycle and checks it end to end; returns in the next IDLE cycle
  task automatic run_op(input string name, input logic s, input logic [31:0] a, input logic [31:0] b,
                        input int n, input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                        output logic [31:0] mag_a);
    int starts, lat, exp_lat;
    bit got, stall_ok, we;
    logic [63:0] exp;
    logic [31:0] lo, hi;
    core_n = n;
    exp_lat = (b == 32'd0) ? 2 : ((n == 0) ? 5 : n + 4);
    sb_q.push_back({exp_lo, exp_hi});
    req_valid = 1'b1; req_signed = s; req_a = a; req_b = b;
    #1;
    check_cnt++;
    if (stall !== 1'b1) $display("FAIL %s stall_accept: got %b want 1", name, stall);
    else pass_cnt++;
    @(posedge clk); #1;
    req_valid = 1'b0; req_signed = ~s; req_a = $urandom; req_b = $urandom;
    starts = 0; got = 1'b0; stall_ok = 1'b1; lat = 0; we = 1'b0; mag_a = '0; lo = '0; hi = '0;
    for (int c = 1; c <= 200; c++) begin
      if (div_start) begin starts++; mag_a = div_a; end
      if (stall !== 1'b1) stall_ok = 1'b0;
      if (done) begin
        got = 1'b1; lat = c; we = hilo_we; lo = lo_out; hi = hi_out;
        break;
      end
      if (hilo_we || err) stall_ok = 1'b0;
      @(posedge clk); #1;
    end
    check_cnt++;
    if (!got) $display("FAIL %s done_timeout: got no done want done", name);
    else pass_cnt++;
    exp = sb_q.pop_front();
    check_cnt++;
    if (lo !== exp[63:32]) $display("FAIL %s lo: got %h want %h", name, lo, exp[63:32]);
    else pass_cnt++;
    check_cnt++;
    if (hi !== exp[31:0]) $display("FAIL %s hi: got %h want %h", name, hi, exp[31:0]);
    else pass_cnt++;
    check_cnt++;
    if (lat !== exp_lat) $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    else pass_cnt++;
    check_cnt++;
    if (we !== 1'b1) $display("FAIL %s hilo_we: got %b want 1", name, we);
    else pass_cnt++;
    check_cnt++;
    if (starts !== ((b == 32'd0) ? 0 : 1))
      $display("FAIL %s start_pulses: got %0d want %0d", name, starts, (b == 32'd0) ? 0 : 1);
    else pass_cnt++;
    check_cnt++;
    if (!stall_ok) $display("FAIL %s stall_or_early_write: got bad want stall=1 no we/err", name);
    else pass_cnt++;
    @(posedge clk); #1;
    check_cnt++;
    if ({done, hilo_we} !== 2'b00) $display("FAIL %s done_pulse: got %b want 00", name, {done, hilo_we});
    else pass_cnt++;
  endtask

  task automatic test_hold(input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    repeat (4) @(posedge clk);
    #1;
    check_cnt++;
    if ({lo_out, hi_out} !== {exp_lo, exp_hi})
      $display("FAIL hold: got %h want %h", {lo_out, hi_out}, {exp_lo, exp_hi});
    else pass_cnt++;
    check_cnt++;
    if (stall !== 1'b0) $display("FAIL idle_stall: got %b want 0", stall);
    else pass_cnt++;
  endtask

  task automatic test_timeout(input logic [31:0] prev_lo, input logic [31:0] prev_hi);
    int err_cyc;
    bit bad_we;
    stub = 1'b1; core_n = 4;
    req_valid = 1'b1; req_signed = 1'b0; req_a = 32'd100; req_b = 32'd3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    err_cyc = 0; bad_we = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      if (hilo_we || done) bad_we = 1'b1;
      if (err) begin err_cyc = c; break; end
      @(posedge clk); #1;
    end
    check_cnt++;
    if (err_cyc !== TIMEOUT + 1) $display("FAIL timeout_err_cycle: got %0d want %0d", err_cyc, TIMEOUT + 1);
    else pass_cnt++;
    check_cnt++;
    if (bad_we) $display("FAIL timeout_no_write: got write want none");
    else pass_cnt++;
    check_cnt++;
    if ({lo_out, hi_out} !== {prev_lo, prev_hi})
      $display("FAIL timeout_hold: got %h want %h", {lo_out, hi_out}, {prev_lo, prev_hi});
    else pass_cnt++;
    @(posedge clk); #1;
    check_cnt++;
    if ({err, stall} !== 2'b00) $display("FAIL timeout_err_pulse: got %b want 00", {err, stall});
    else pass_cnt++;
    stub = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    bit bad;
    core_n = 20;
    req_valid = 1'b1; req_signed = 1'b0; req_a = 32'd1000; req_b = 32'd7;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_cnt++;
    if ({stall, done, hilo_we, div_start} !== 4'b0)
      $display("FAIL rst_mid_ctl: got %b want 0000", {stall, done, hilo_we, div_start});
    else pass_cnt++;
    bad = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (done || hilo_we || stall) bad = 1'b1;
      @(posedge clk); #1;
    end
    check_cnt++;
    if (bad) $display("FAIL rst_mid_no_write: got activity want idle");
    else pass_cnt++;
  endtask

  initial begin
    logic [31:0] mag;
    logic [63:0] e;
    logic [31:0] ra, rb;
    logic rs;
    test_reset();
    run_op("divu_big", 1'b0, 32'hFFFF_FFF0, 32'd5, 32, 32'h3333_3330, 32'h0, mag);
    run_op("div_neg16", 1'b1, 32'hFFFF_FFF0, 32'd5, 3, 32'hFFFF_FFFD, 32'hFFFF_FFFF, mag);
    check_cnt++;
    if (mag !== 32'd16) $display("FAIL div_neg16_mag: got %h want %h", mag, 32'd16);
    else pass_cnt++;
    run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 32'h0, mag);
    run_op("divu_neg_b", 1'b0, 32'hFFFF_0000, 32'hFFFF_FFFE, 5, 32'h0, 32'hFFFF_0000, mag);
    run_op("div_neg_both", 1'b1, 32'hFFFF_0000, 32'hFFFF_FFFE, 2, 32'h0000_8000, 32'h0, mag);
    run_op("divu_zero", 1'b0, 32'd7, 32'd0, 4, 32'hFFFF_FFFF, 32'd7, mag);
    run_op("div_no_busy", 1'b1, 32'd100, 32'hFFFF_FFF9, 0, 32'hFFFF_FFF2, 32'd2, mag);
    for (int i = 0; i < 4; i++) begin
      rs = i[0]; ra = $urandom; rb = $urandom_range(1, 5000);
      if (i == 3) rb = -rb;
      e = ref_div(rs, ra, rb);
      run_op("rand", rs, ra, rb, $urandom_range(1, 8), e[63:32], e[31:0], mag);
    end
    test_hold(e[63:32], e[31:0]);
    test_timeout(e[63:32], e[31:0]);
    test_reset_mid_run();
    run_op("after_rst", 1'b0, 32'd26, 32'd5, 6, 32'd5, 32'd1, mag);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
